// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NREQ valid/ready producers.
// Define FIFO_ARB_TAG_EN to prepend the grantee index to each written word.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       clear,
  input  logic                       fifo_full,
  output logic                       fifo_we,
`ifdef FIFO_ARB_TAG_EN
  output logic [$clog2(NREQ)+WIDTH-1:0] fifo_wdata,
`else
  output logic [WIDTH-1:0]           fifo_wdata,
`endif
  output logic                       fifo_clear,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_L = (IDW+1)'(NREQ);
  localparam logic [7:0] BURST_L = 8'(BURST_LEN);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [7:0]     burst_cnt;

  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  logic [IDW:0]   pos;
  logic           grant;
  logic [IDW-1:0] gnt_idx;
  logic           accept;
  logic [7:0]     burst_cnt_inc;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (i == IDW'(NREQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Descending scan so the lowest offset from rr_ptr is the last (winning) match.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    pos       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= NREQ_L) pos = pos - NREQ_L;
      if (req_valid[pos[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    if (state == ST_LOCK) begin
      grant   = req_valid[owner];
      gnt_idx = owner;
    end else begin
      grant   = arb_found;
      gnt_idx = arb_idx;
    end
  end

  assign accept        = grant && !fifo_full && !clear && !rst;
  assign fifo_we       = accept;
  assign fifo_clear    = clear;
  assign burst_cnt_inc = burst_cnt + 8'd1;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

`ifdef FIFO_ARB_TAG_EN
  assign fifo_wdata = {gnt_idx, req_data[gnt_idx*WIDTH +: WIDTH]};
`else
  assign fifo_wdata = req_data[gnt_idx*WIDTH +: WIDTH];
`endif

  // A stall (fifo_full) in LOCK holds everything; only a dropped valid ends a burst early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
    end else if (clear) begin
      state     <= ST_ARB;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (accept) begin
            grant_id <= gnt_idx;
            if (BURST_LEN == 1) begin
              rr_ptr <= next_idx(gnt_idx);
            end else begin
              state     <= ST_LOCK;
              owner     <= gnt_idx;
              burst_cnt <= 8'd1;
            end
          end
        end
        ST_LOCK: begin
          if (accept) begin
            grant_id  <= owner;
            burst_cnt <= burst_cnt_inc;
            if (burst_cnt_inc == BURST_L) begin
              state  <= ST_ARB;
              rr_ptr <= next_idx(owner);
            end
          end else if (!fifo_full && !req_valid[owner]) begin
            state  <= ST_ARB;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule
